// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
// Shared types and sizing helpers for the sequential divider.
//   state_t  : divider FSM states (IDLE, CALC, DONE)
//   count_w  : width of the iteration counter for a given operand WIDTH
// Configuration macro: SEQ_DIVIDER_SIGNED_EN (consumed by seq_divider.sv).
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter runs WIDTH-1 down to 0, so $clog2(WIDTH) bits suffice.
    function automatic int count_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_divider_prefix_sub.sv
// prefix_sub
// Combinational Kogge-Stone subtractor: diff = a - b computed as a + ~b + 1.
//   N      : operand width
//   a, b   : operands (unsigned)
//   diff   : a - b modulo 2^N
//   borrow : 1 when a < b (unsigned), i.e. the true difference is negative
module prefix_sub #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    localparam int L = (N < 2) ? 1 : $clog2(N);

    logic [N-1:0] g_l [0:L];
    logic [N-1:0] p_l [0:L];

    always_comb begin
        for (int k = 0; k <= L; k++) begin
            g_l[k] = '0;
            p_l[k] = '0;
        end
        g_l[0] = a & ~b;
        p_l[0] = a ^ ~b;
        // Carry-in of 1 folds into bit 0's group generate.
        g_l[0][0] = g_l[0][0] | p_l[0][0];
        for (int k = 1; k <= L; k++) begin
            for (int i = 0; i < N; i++) begin
                if (i >= (1 << (k - 1))) begin
                    g_l[k][i] = g_l[k-1][i] | (p_l[k-1][i] & g_l[k-1][i - (1 << (k - 1))]);
                    p_l[k][i] = p_l[k-1][i] & p_l[k-1][i - (1 << (k - 1))];
                end else begin
                    g_l[k][i] = g_l[k-1][i];
                    p_l[k][i] = p_l[k-1][i];
                end
            end
        end
    end

    // Carry into bit i is the group generate of bits [i-1:0]; bit 0 sees the carry-in.
    assign diff   = p_l[0] ^ {g_l[L][N-2:0], 1'b1};
    assign borrow = ~g_l[L][N-1];

endmodule

// File: rtl/seq_divider.sv
// seq_divider
// Radix-2 restoring divider, one quotient bit per clock.
// Configuration macro: SEQ_DIVIDER_SIGNED_EN (two's-complement operands).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (dividend, divisor sampled on accept)
//   out_valid/out_ready : result handshake (quotient, remainder, div_by_zero)
//   state_dbg           : current FSM state
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid/ready outputs are decoded from the state register only, so neither
// in_valid nor out_ready reaches any output combinationally.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output state_t           state_dbg
);

    localparam int COUNT_W = count_w(WIDTH);
    localparam logic [COUNT_W-1:0] CNT_LOAD = COUNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   r_q, q_q, d_q;
    logic [COUNT_W-1:0] cnt_q;

    logic               zero_div;
    logic [WIDTH:0]     sub_a, sub_b, sub_diff;
    logic               sub_borrow;
    logic               unused_diff_msb;
    logic [WIDTH-1:0]   r_nxt, q_nxt, q_res, r_res;
    logic [WIDTH-1:0]   dvd_mag, dvs_mag;

    assign zero_div  = (divisor == '0);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign state_dbg = state_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = zero_div ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- trial subtraction ----------------
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic q_neg_q, r_neg_q;

    // Outside CALC the subtractor is idle, so it negates the dividend at load.
    always_comb begin
        if (state_q == CALC) begin
            sub_a = {r_q, q_q[WIDTH-1]};
            sub_b = {1'b0, d_q};
        end else begin
            sub_a = '0;
            sub_b = {1'b0, dividend};
        end
    end
    assign dvd_mag = dividend[WIDTH-1] ? sub_diff[WIDTH-1:0] : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
`else
    assign sub_a   = {r_q, q_q[WIDTH-1]};
    assign sub_b   = {1'b0, d_q};
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
`endif

    prefix_sub #(.N(WIDTH + 1)) u_sub (
        .a      (sub_a),
        .b      (sub_b),
        .diff   (sub_diff),
        .borrow (sub_borrow)
    );

    // The difference fits in WIDTH bits whenever it is non-negative.
    assign unused_diff_msb = sub_diff[WIDTH];

    assign r_nxt = sub_borrow ? {r_q[WIDTH-2:0], q_q[WIDTH-1]} : sub_diff[WIDTH-1:0];
    assign q_nxt = {q_q[WIDTH-2:0], ~sub_borrow};

`ifdef SEQ_DIVIDER_SIGNED_EN
    assign q_res = q_neg_q ? (~q_nxt + 1'b1) : q_nxt;
    assign r_res = r_neg_q ? (~r_nxt + 1'b1) : r_nxt;
`else
    assign q_res = q_nxt;
    assign r_res = r_nxt;
`endif

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (zero_div) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            r_q   <= '0;
                            q_q   <= dvd_mag;
                            d_q   <= dvs_mag;
                            cnt_q <= CNT_LOAD;
`ifdef SEQ_DIVIDER_SIGNED_EN
                            q_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_neg_q <= dividend[WIDTH-1];
`endif
                        end
                    end
                end
                CALC: begin
                    r_q <= r_nxt;
                    q_q <= q_nxt;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        quotient    <= q_res;
                        remainder   <= r_res;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
// Self-checking bench for seq_divider at WIDTH=8. Expected results come from a
// behavioural model, are queued when operands are accepted and compared when
// the result is consumed.
module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    state_t       state_dbg;

    logic [2*W:0] exp_q[$];   // {div_by_zero, quotient, remainder}
    int n_cmp = 0;
    int n_err = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r;
`ifdef SEQ_DIVIDER_SIGNED_EN
        logic signed [W-1:0] sa, sb;
        logic [W-1:0] min_v, neg_one;
        min_v   = {1'b1, {(W-1){1'b0}}};
        neg_one = '1;
`endif
        if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (a == min_v && b == neg_one) return {1'b0, min_v, {W{1'b0}}};
        sa = a;
        sb = b;
        q = sa / sb;
        r = sa % sb;
`else
        q = a / b;
        r = a % b;
`endif
        return {1'b0, q, r};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for the accept edge, queue the expected result.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_q.push_back(model(a, b));
    endtask

    // Called just after the accept edge; counts further edges until out_valid.
    task automatic wait_result(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!out_valid && n < W + 10) begin tick(); n++; end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    endtask

    // Holds out_ready low for 'hold' cycles, then compares and consumes.
    task automatic collect(input string tag, input int hold);
        logic [2*W:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q[0];
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_q"}, 32'(quotient), 32'(e[2*W-1:W]));
            check({tag, "_hold_busy"}, 32'({out_valid, in_ready}), 32'b10);
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_quot"}, 32'(quotient), 32'(e[2*W-1:W]));
        check({tag, "_rem"}, 32'(remainder), 32'(e[W-1:0]));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(e[2*W]));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        check({tag, "_idle"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold);
        send(a, b);
        wait_result(tag, (b == '0) ? 0 : W);
        collect(tag, hold);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] a, b;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quot", 32'(quotient), 32'd0);
        check("rst_rem", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));

        // Directed cases
        run_op("d200_7", 8'd200, 8'd7, 0);
        run_op("dz_5a", 8'h5A, 8'd0, 0);
        run_op("d255_1", 8'd255, 8'd1, 1);
        run_op("d3_200", 8'd3, 8'd200, 0);
        run_op("d0_9", 8'd0, 8'd9, 0);
        run_op("d128_2", 8'd128, 8'd2, 2);
`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op("s_m7_2", 8'hF9, 8'd2, 0);
        run_op("s_min_m1", 8'h80, 8'hFF, 0);
        run_op("s_7_m2", 8'd7, 8'hFE, 0);
`endif

        // Long stall: outputs held, new operands ignored, accept after release
        send(8'd10, 8'd3);
        wait_result("stall", W);
        dividend = 8'd77;
        divisor  = 8'd5;
        in_valid = 1'b1;
        collect("stall", 20);
        check("stall_accept_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        exp_q.push_back(model(8'd77, 8'd5));
        check("stall_accepted", 32'(in_ready), 32'd0);
        wait_result("post_stall", W);
        collect("post_stall", 0);

        // Reset in the middle of CALC discards the operation
        send(8'd50, 8'd3);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_quot", 32'(quotient), 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        run_op("d255_255", 8'd255, 8'd255, 0);

        // Random pairs with random output stalls and idle gaps
        for (int i = 0; i < 2000; i++) begin
            a = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       b = 8'($urandom_range(0, 3));
                1:       b = 8'($urandom_range(1, 15));
                default: b = 8'($urandom_range(0, 255));
            endcase
            repeat ($urandom_range(0, 2)) tick();
            run_op("rand", a, b, $urandom_range(0, 3));
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
